// File: rtl/clm_unmask_p_pkg.sv
// Shared types for the CLM unmasking decoder.
//   N_LANES  : lanes per state (16)
//   D_DEF    : default redundancy degree d
//   LANE_W   : lane width 8+d at the default degree
//   P_DEF    : default monic degree-8 code polynomial
//   state_t  : 16 lanes packed, lane k at [k*LANE_W +: LANE_W]
//   q_vec_t  : 16 quotients packed, quotient k at [k*D_DEF +: D_DEF]
//   fsm_t    : decoder control states
package clm_unmask_p_pkg;

  localparam int unsigned N_LANES = 16;
  localparam int unsigned D_DEF   = 4;
  localparam int unsigned LANE_W  = 8 + D_DEF;
  localparam logic [8:0]  P_DEF   = 9'h11B;
  localparam int unsigned CNT_W   = 4;

  typedef logic [N_LANES*LANE_W-1:0] state_t;
  typedef logic [N_LANES*D_DEF-1:0]  q_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  function automatic int unsigned lane_w(input int unsigned dd);
    return 8 + dd;
  endfunction

  // d=0 leaves no quotient; the field collapses to a single bit tied to zero.
  function automatic int unsigned q_w(input int unsigned dd);
    return (dd == 0) ? 1 : N_LANES * dd;
  endfunction

endpackage

// File: rtl/clm_unmask_p_if.sv
// Handshake bundle of the CLM unmasking decoder.
//   in_valid/in_ready/in_state : masked state input, 16 lanes of 8+d bits
//   abort                      : synchronous cancel of the job in flight
//   out_valid/out_ready        : result hand-off
//   out_data                   : 16 recovered bytes, byte k at [8k +: 8]
//   out_q                      : 16 quotients of d bits (1-bit zero when d=0)
// master = producer/consumer side, slave = decoder side.
interface clm_unmask_p_if
  import clm_unmask_p_pkg::*;
#(
  parameter int unsigned d = D_DEF
);
  localparam int unsigned W  = lane_w(d);
  localparam int unsigned QW = q_w(d);

  logic                  in_valid;
  logic                  in_ready;
  logic [N_LANES*W-1:0]  in_state;
  logic                  abort;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_LANES*8-1:0]  out_data;
  logic [QW-1:0]         out_q;

  modport master (
    output in_valid, in_state, abort, out_ready,
    input  in_ready, out_valid, out_data, out_q
  );

  modport slave (
    input  in_valid, in_state, abort, out_ready,
    output in_ready, out_valid, out_data, out_q
  );

endinterface

// File: rtl/clm_unmask_p_reduce_step.sv
// One GF(2) long-division step for a single lane.
//   lane_i : current lane value (W bits)
//   idx    : step index; the bit examined is 8+idx
//   poly   : monic degree-8 divisor P
//   lane_o : lane with P<<idx cancelled when bit 8+idx is set
//   qbit   : quotient bit idx (equals the examined lane bit)
module clm_reduce_step
  import clm_unmask_p_pkg::*;
#(
  parameter int unsigned W = LANE_W
) (
  input  logic [W-1:0]     lane_i,
  input  logic [CNT_W-1:0] idx,
  input  logic [8:0]       poly,
  output logic [W-1:0]     lane_o,
  output logic             qbit
);

  logic [W-1:0] pw;
  logic [W-1:0] lead;

  always_comb begin
    pw       = '0;
    pw[8:0]  = poly;
    pw       = pw << idx;
    lead     = '0;
    lead[8]  = 1'b1;
    lead     = lead << idx;
    qbit     = |(lane_i & lead);
    lane_o   = qbit ? (lane_i ^ pw) : lane_i;
  end

endmodule

// File: rtl/clm_unmask_p.sv
// CLM unmasking decoder: splits each of 16 lanes x + r*P into
// x = lane mod P and r = lane div P by d GF(2) division steps,
// one step for all lanes per clock, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : clm_unmask_p_if slave (input state, abort, result hand-off)
module clm_unmask_p
  import clm_unmask_p_pkg::*;
#(
  parameter int unsigned d = D_DEF,
  parameter logic [8:0]  P = P_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  clm_unmask_p_if.slave  bus
);

  localparam int unsigned W  = lane_w(d);
  localparam int unsigned QW = q_w(d);

  fsm_t                  st;
  logic [N_LANES*W-1:0]  lanes;
  logic [N_LANES*W-1:0]  lanes_nx;
  logic [QW-1:0]         q;
  logic [QW-1:0]         q_nx;
  logic [CNT_W-1:0]      cnt;
  logic                  in_ready_r;
  logic                  out_valid_r;

  generate
    if (d == 0) begin : g_nostep
      assign lanes_nx = lanes;
      assign q_nx     = '0;
    end else begin : g_step
      localparam logic [d-1:0] QONE = (d)'(1);
      for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic         qb;
        logic [d-1:0] qsel;

        clm_reduce_step #(.W(W)) u_step (
          .lane_i (lanes[k*W +: W]),
          .idx    (cnt),
          .poly   (P),
          .lane_o (lanes_nx[k*W +: W]),
          .qbit   (qb)
        );

        // Write quotient bit cnt explicitly (set or clear) rather than shift in.
        assign qsel = QONE << cnt;
        assign q_nx[k*d +: d] = qb ? (q[k*d +: d] | qsel) : (q[k*d +: d] & ~qsel);
      end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_out
      assign bus.out_data[8*k +: 8] = lanes[k*W +: 8];
    end
  endgenerate

  assign bus.out_q     = q;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      lanes       <= '0;
      q           <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            lanes      <= bus.in_state;
            q          <= '0;
            in_ready_r <= 1'b0;
            if (d == 0) begin
              cnt         <= '0;
              out_valid_r <= 1'b1;
              st          <= DONE;
            end else begin
              cnt <= CNT_W'(d - 1);
              st  <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            st         <= IDLE;
            in_ready_r <= 1'b1;
          end else begin
            lanes <= lanes_nx;
            q     <= q_nx;
            if (cnt == '0) begin
              st          <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.abort || bus.out_ready) begin
            st          <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          st          <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_unmask_p.sv
// Bench for clm_unmask_p: directed cases at d=4 plus randomized
// x/r round trips at d=0 and d=8 against a masking model.
module tb_clm_unmask_p;
  import clm_unmask_p_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  clm_unmask_p_if #(.d(4)) if4 ();
  clm_unmask_p_if #(.d(0)) if0 ();
  clm_unmask_p_if #(.d(8)) if8 ();

  clm_unmask_p #(.d(4), .P(9'h11B)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  clm_unmask_p #(.d(0), .P(9'h11B)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  clm_unmask_p #(.d(8), .P(9'h11B)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Masking model: lane = x ^ r*P over GF(2).
  function automatic logic [15:0] mask_lane(input logic [7:0] x, input logic [7:0] r,
                                            input int unsigned dd);
    logic [15:0] v;
    v = {8'h00, x};
    for (int unsigned b = 0; b < dd; b++)
      if (r[b]) v ^= 16'(P_DEF) << b;
    return v;
  endfunction

  task automatic gen(input int unsigned dd, output logic [255:0] st,
                     output logic [127:0] ed, output logic [127:0] eq);
    st = '0; ed = '0; eq = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      logic [7:0] x, r;
      x  = 8'($urandom_range(0, 255));
      r  = 8'($urandom_range(0, (1 << dd) - 1));
      st |= 256'(mask_lane(x, r, dd)) << (k * (8 + dd));
      ed |= 128'(x) << (8 * k);
      eq |= 128'(r) << (k * dd);
    end
  endtask

  function automatic logic ir(input int s);
    case (s)
      0: return if0.in_ready;
      4: return if4.in_ready;
      default: return if8.in_ready;
    endcase
  endfunction

  function automatic logic ov(input int s);
    case (s)
      0: return if0.out_valid;
      4: return if4.out_valid;
      default: return if8.out_valid;
    endcase
  endfunction

  function automatic logic [127:0] od(input int s);
    case (s)
      0: return if0.out_data;
      4: return if4.out_data;
      default: return if8.out_data;
    endcase
  endfunction

  function automatic logic [127:0] oq(input int s);
    case (s)
      0: return 128'(if0.out_q);
      4: return 128'(if4.out_q);
      default: return 128'(if8.out_q);
    endcase
  endfunction

  task automatic drv(input int s, input logic v, input logic [255:0] st);
    case (s)
      0: begin if0.in_valid = v; if0.in_state = st[127:0]; end
      4: begin if4.in_valid = v; if4.in_state = st[191:0]; end
      default: begin if8.in_valid = v; if8.in_state = st; end
    endcase
  endtask

  // Present a state, wait (bounded) for in_ready, take the accept edge.
  task automatic accept(input int s, input logic [255:0] st, output int unsigned t_acc);
    int w;
    drv(s, 1'b1, st);
    w = 0;
    while (!ir(s) && w < 40) begin @(posedge clk); #1; w++; end
    chk("accept in_ready", ir(s), 1'b1);
    t_acc = cyc;
    @(posedge clk); #1;
    drv(s, 1'b0, '1);
  endtask

  // Cycles from accept edge until out_valid, capped at 40.
  task automatic wait_out(input int s, output int lat);
    lat = 1;
    while (!ov(s) && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic rand_run(input int s, input int n);
    logic [255:0] st;
    logic [127:0] ed, eq;
    int unsigned t_acc, t_prev;
    int lat;
    t_prev = 0;
    for (int t = 0; t < n; t++) begin
      gen(s, st, ed, eq);
      accept(s, st, t_acc);
      if (t > 0) chk($sformatf("d%0d accept period", s), t_acc - t_prev, s + 2);
      t_prev = t_acc;
      wait_out(s, lat);
      chk($sformatf("d%0d latency", s), lat, s + 1);
      chk($sformatf("d%0d out_data", s), od(s), ed);
      chk($sformatf("d%0d out_q", s), oq(s), eq);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"},  ir(4), 1'b1);
    chk({tag, " out_valid"}, ov(4), 1'b0);
    chk({tag, " out_data"},  od(4), '0);
    chk({tag, " out_q"},     oq(4), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] st, s_t2;
    logic [127:0] ed, eq, ed_t2, eq_t2;
    int unsigned t_acc;
    int lat;

    s_t2  = 256'({{14{12'h0AB}}, 12'hF66, 12'h37E});
    ed_t2 = {{14{8'hAB}}, 8'hFF, 8'h53};
    eq_t2 = 128'({{14{4'h0}}, 4'hF, 4'h3});

    if4.in_valid = 0; if4.in_state = '0; if4.abort = 0; if4.out_ready = 1;
    if0.in_valid = 0; if0.in_state = '0; if0.abort = 0; if0.out_ready = 1;
    if8.in_valid = 0; if8.in_state = '0; if8.abort = 0; if8.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All lanes = P; abort held across the IDLE accept must be ignored.
    if4.abort = 1'b1;
    accept(4, 256'({16{12'h11B}}), t_acc);
    if4.abort = 1'b0;
    chk("t1 in_ready in RUN", ir(4), 1'b0);
    wait_out(4, lat);
    chk("t1 latency", lat, 5);
    chk("t1 out_data", od(4), '0);
    chk("t1 out_q", oq(4), 128'({16{4'h1}}));
    @(posedge clk); #1;
    chk("t1 out_valid after hand-off", ov(4), 1'b0);
    chk("t1 in_ready after hand-off", ir(4), 1'b1);

    // Mixed lanes, then stall the consumer for 10 cycles.
    accept(4, s_t2, t_acc);
    wait_out(4, lat);
    chk("t2 latency", lat, 5);
    chk("t2 out_data", od(4), ed_t2);
    chk("t2 out_q", oq(4), eq_t2);
    if4.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gen(4, st, ed, eq);
      drv(4, 1'b1, st);
      @(posedge clk); #1;
      chk("hold out_valid", ov(4), 1'b1);
      chk("hold in_ready", ir(4), 1'b0);
      chk("hold out_data", od(4), ed_t2);
      chk("hold out_q", oq(4), eq_t2);
    end
    drv(4, 1'b0, '0);
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release out_valid", ov(4), 1'b0);
    chk("hold release in_ready", ir(4), 1'b1);

    // Asynchronous reset in the second RUN cycle.
    gen(4, st, ed, eq);
    accept(4, st, t_acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(4, s_t2, t_acc);
    wait_out(4, lat);
    chk("post-reset latency", lat, 5);
    chk("post-reset out_data", od(4), ed_t2);
    chk("post-reset out_q", oq(4), eq_t2);
    @(posedge clk); #1;

    // Abort in the second RUN cycle, then a fresh job.
    gen(4, st, ed, eq);
    accept(4, st, t_acc);
    @(posedge clk); #1;
    if4.abort = 1'b1;
    @(posedge clk); #1;
    if4.abort = 1'b0;
    chk("abort out_valid", ov(4), 1'b0);
    chk("abort in_ready", ir(4), 1'b1);
    gen(4, st, ed, eq);
    accept(4, st, t_acc);
    wait_out(4, lat);
    chk("after abort latency", lat, 5);
    chk("after abort out_data", od(4), ed);
    chk("after abort out_q", oq(4), eq);
    @(posedge clk); #1;

    rand_run(4, 4);
    rand_run(0, 8);
    rand_run(8, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clm_unmask_p.md
# clm_unmask_p

Unmasking decoder for the CLM datapath, the inverse of the random-codeword masking stage. It accepts a masked state of 16 lanes, each lane an (8+d)-bit polynomial `x(X) + r(X)·P(X)`, and recovers the data byte `x = lane mod P` and the mask quotient `r = lane div P` for every lane. The reduction is iterative: one long-division step for all 16 lanes in parallel per clock, over d clocks. It sits at the CLM output boundary, after the last masked round, and uses valid/ready handshakes on both sides.

## Interface
- `d`, default 4: redundancy degree; lane width W = 8+d; legal range 0..8.
- `P`, default 9'h11B: monic degree-8 code polynomial; bit 8 must be 1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_state` holds a masked state.
- `in_ready` out 1: block can accept a state.
- `in_state` in `state_t` (16·W): lane k is bits [k·W +: W].
- `abort` in 1: synchronous cancel of the job in flight.
- `out_valid` out 1: result registers hold a completed decode.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 128: byte k is bits [8k +: 8] = lane k mod P.
- `out_q` out 16·d: quotient k is bits [k·d +: d] = lane k div P; zero width is legal when d=0 (port unused).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch all lanes into the working register, clear the quotient register, load the step counter with d-1, and go to RUN. When d=0, go directly to DONE with `out_data` equal to the low 8 bits of each lane.
- RUN: each clock processes bit position i = 8+cnt in every lane. If bit i is 1, XOR `P << (i-8)` into the lane and set quotient bit (i-8). Otherwise leave the lane unchanged and clear that quotient bit. Decrement cnt. After the step with cnt=0, go to DONE.
- DONE: `out_valid`=1. `out_data` is the low 8 bits of each working lane, and the upper d bits of each lane are guaranteed zero. On `out_ready`, go to IDLE.
- `abort` in RUN or DONE returns to IDLE next clock and drops `out_valid`. `abort` takes priority over `out_ready`. `abort` in IDLE has no effect.
- `in_ready` is low in RUN and DONE. There is no input buffering, so a new state is accepted only from IDLE.
- Arithmetic is GF(2) only: XOR, no carries. The quotient for each lane is built MSB-first.

## Timing
- Reset values: FSM=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_q`=0, cnt=0.
- Reset asserted in any state returns the block to reset values immediately. The partial result is discarded.
- Latency: a handshake on `in_valid` in cycle 0 raises `out_valid` in cycle d+1. For d=0 it rises in cycle 1.
- Throughput: one state per d+2 cycles when `out_ready` is held high (accept, d steps, hand-off). After the DONE→IDLE clock, `in_ready` is high again.
- `out_data` and `out_q` stay stable while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- `in_valid` and `in_state` are sampled only in IDLE. Changes to them during RUN or DONE are ignored.

## Structure
- The shared `types` package holds: `state_t`, lane count 16, `LANE_W = 8+d`, the default `P`, and `q_vec_t` (16·d).
- Sub-module `clm_reduce_step`: combinational one-lane step. Inputs are the lane, the step index and P. Outputs are the next lane and the quotient bit. It is instantiated 16× in the top, which holds the FSM, counter and registers.

## Test plan
- d=4, P=0x11B, all lanes = 0x11B (x=0x00, r=0x1) → `out_data` all 0x00, each `out_q` nibble 0x1, `out_valid` in cycle 5.
- d=4, lane 0 = 0x37E (x=0x53, r=0x3), lane 1 = 0xF66 (x=0xFF, r=0xF), other lanes = 0x0AB → bytes 0x53, 0xFF, 0xAB…; q = 0x3, 0xF, 0x0….
- Hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0 throughout, and `in_valid` pulses are ignored.
- Assert `rst_n`=0 in cycle 2 of RUN → all outputs return to reset values without waiting for a clock. The next accepted state decodes correctly.
- Assert `abort` in cycle 2 of RUN, then send a new state → the first job produces no `out_valid`. The second completes with latency d+1.
- Randomized with d=0 and d=8: x and r random, lane = x ^ r·P → `out_data`=x and `out_q`=r for every lane, and back-to-back throughput is d+2.
